// File: rtl/ov7670_pkg.sv
// rtl/ov7670_pkg.sv - shared frame geometry, pixel type and writer states for the OV7670 path
package ov7670_pkg;

  localparam int H_PIX     = 320;
  localparam int V_LINES   = 240;
  localparam int FRAME_PIX = H_PIX * V_LINES;
  localparam int AW        = 17;
  localparam int DW        = 12;

  typedef logic [DW-1:0] pixel_t;

  typedef enum logic [2:0] {
    SYNC,
    CAPTURE,
    COMMIT,
    WAIT,
    FROZEN
  } fbw_state_e;

endpackage

// File: rtl/vsync_edge_det.sv
// rtl/vsync_edge_det.sv - one-register rise/fall detector, shared with the display side
module vsync_edge_det (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_sig,
  output logic o_rise,
  output logic o_fall
);

  logic r_sig_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sig_q <= 1'b0;
    end else begin
      r_sig_q <= i_sig;
    end
  end

  assign o_rise = i_sig & ~r_sig_q;
  assign o_fall = ~i_sig & r_sig_q;

endmodule

// File: rtl/ov7670_frame_bank_writer.sv
// rtl/ov7670_frame_bank_writer.sv - steers captured pixels into the back bank of a two-bank
// frame RAM and publishes only frames that completed with the exact pixel count
module ov7670_frame_bank_writer #(
  parameter int H_PIX   = ov7670_pkg::H_PIX,
  parameter int V_LINES = ov7670_pkg::V_LINES,
  parameter int AW      = ov7670_pkg::AW,
  parameter int DW      = ov7670_pkg::DW
) (
  input  logic          i_pclk,
  input  logic          i_reset,
  input  logic          i_vsync,
  input  logic          i_cap_we,
  input  logic [AW-1:0] i_cap_addr,
  input  logic [DW-1:0] i_cap_data,
  input  logic          i_freeze,
  output logic          o_mem_we,
  output logic [AW:0]   o_mem_addr,
  output logic [DW-1:0] o_mem_data,
  output logic          o_disp_bank,
  output logic          o_frame_done,
  output logic          o_frame_err,
  output logic          o_frozen
);

  import ov7670_pkg::*;

  localparam int            FRAME_N   = H_PIX * V_LINES;
  localparam logic [AW-1:0] FRAME_CNT = FRAME_N[AW-1:0];

  fbw_state_e r_state;
  fbw_state_e w_state_nxt;

  logic          w_rise;
  logic          w_fall;
  logic          w_clear;
  logic          w_cap;
  logic          w_in_range;
  logic          w_commit;
  logic          w_good;

  logic          r_mem_we;
  logic [AW:0]   r_mem_addr;
  logic [DW-1:0] r_mem_data;
  logic          r_disp_bank;
  logic          r_wr_bank;
  logic          r_frame_done;
  logic          r_frame_err;
  logic [AW-1:0] r_pix_cnt;
  logic          r_range_err;

  vsync_edge_det u_vsync_edge (
    .i_clk   (i_pclk),
    .i_reset (i_reset),
    .i_sig   (i_vsync),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  always_ff @(posedge i_pclk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= SYNC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // SYNC exists so a frame already in flight at reset is never captured.
  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    case (r_state)
      SYNC, WAIT: begin
        if (w_fall) begin
          w_state_nxt = CAPTURE;
          w_clear     = 1'b1;
        end
      end
      CAPTURE: begin
        if (w_rise) begin
          w_state_nxt = COMMIT;
        end
      end
      COMMIT: begin
        w_state_nxt = i_freeze ? FROZEN : WAIT;
      end
      FROZEN: begin
        if (!i_freeze && w_fall) begin
          w_state_nxt = CAPTURE;
          w_clear     = 1'b1;
        end
      end
      default: begin
        w_state_nxt = SYNC;
      end
    endcase
  end

  assign w_cap      = (r_state == CAPTURE) & i_cap_we;
  assign w_in_range = i_cap_addr < FRAME_CNT;
  assign w_commit   = (r_state == COMMIT);
  assign w_good     = (r_pix_cnt == FRAME_CNT) & ~r_range_err;

  always_ff @(posedge i_pclk or posedge i_reset) begin
    if (i_reset) begin
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_data   <= '0;
      r_disp_bank  <= 1'b0;
      r_wr_bank    <= 1'b1;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      r_pix_cnt    <= '0;
      r_range_err  <= 1'b0;
    end else begin
      r_mem_we <= w_cap & w_in_range;
      if (w_cap & w_in_range) begin
        r_mem_addr <= {r_wr_bank, i_cap_addr};
        r_mem_data <= i_cap_data;
      end

      // Saturating count: an overlong frame must never wrap back to a "good" total.
      if (w_clear) begin
        r_pix_cnt   <= '0;
        r_range_err <= 1'b0;
      end else if (w_cap) begin
        if (!w_in_range) begin
          r_range_err <= 1'b1;
        end else if (r_pix_cnt != '1) begin
          r_pix_cnt <= r_pix_cnt + 1'b1;
        end
      end

      r_frame_done <= w_commit & w_good;
      r_frame_err  <= w_commit & ~w_good;
      if (w_commit && w_good) begin
        r_disp_bank <= r_wr_bank;
        r_wr_bank   <= ~r_wr_bank;
      end
    end
  end

  assign o_mem_we     = r_mem_we;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_data   = r_mem_data;
  assign o_disp_bank  = r_disp_bank;
  assign o_frame_done = r_frame_done;
  assign o_frame_err  = r_frame_err;
  assign o_frozen     = (r_state == FROZEN);

endmodule

// File: tb/tb_ov7670_frame_bank_writer.sv
// tb/tb_ov7670_frame_bank_writer.sv - directed frame-table bench for the frame bank writer
module tb_ov7670_frame_bank_writer;

  localparam int AW = 17;
  localparam int DW = 12;
  localparam int HP = 8;
  localparam int VL = 4;
  localparam int FP = HP * VL;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          vsync = 1'b0;
  logic          we = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] data = '0;
  logic          fz = 1'b0;
  logic          o_mem_we;
  logic [AW:0]   o_mem_addr;
  logic [DW-1:0] o_mem_data;
  logic          o_disp_bank;
  logic          o_frame_done;
  logic          o_frame_err;
  logic          o_frozen;

  int n_checks = 0;
  int n_errors = 0;

  ov7670_frame_bank_writer #(
    .H_PIX   (HP),
    .V_LINES (VL),
    .AW      (AW),
    .DW      (DW)
  ) dut (
    .i_pclk       (clk),
    .i_reset      (rst),
    .i_vsync      (vsync),
    .i_cap_we     (we),
    .i_cap_addr   (addr),
    .i_cap_data   (data),
    .i_freeze     (fz),
    .o_mem_we     (o_mem_we),
    .o_mem_addr   (o_mem_addr),
    .o_mem_data   (o_mem_data),
    .o_disp_bank  (o_disp_bank),
    .o_frame_done (o_frame_done),
    .o_frame_err  (o_frame_err),
    .o_frozen     (o_frozen)
  );

  always #5 clk = ~clk;

  // One record per frame: stimulus shape followed by hand-computed expectations.
  typedef struct {
    int n;         // write strobes in the frame
    int bad;       // index whose address is FP (out of range), -1 none
    int rwl;       // last strobe shares the cycle with the vsync rise
    int fz_start;  // freeze level before the frame's falling edge
    int fz_mid;    // index at which freeze is raised, -1 none
    int wr_en;     // writes expected to reach the RAM
    int msb;       // expected bank bit of mem_addr
    int done;
    int err;
    int disp;
    int frozen;
  } frame_vec_t;

  frame_vec_t vecs [12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_frame(input int k);
    frame_vec_t v;
    int exp_we;
    v = vecs[k];
    fz    = (v.fz_start != 0);
    vsync = 1'b0;
    we    = 1'b0;
    tick();
    for (int i = 0; i < v.n; i++) begin
      if (i == v.fz_mid) fz = 1'b1;
      addr = (i == v.bad) ? AW'(FP) : AW'(i % FP);
      data = DW'(i * 37 + k * 5);
      we   = 1'b1;
      if (v.rwl != 0 && i == v.n - 1) vsync = 1'b1;
      tick();
      exp_we = (v.wr_en != 0 && i != v.bad) ? 1 : 0;
      chk($sformatf("f%0d_mem_we_%0d", k, i), 32'(o_mem_we), exp_we);
      if (exp_we != 0) begin
        chk($sformatf("f%0d_mem_addr_%0d", k, i), 32'(o_mem_addr), (v.msb << AW) | (i % FP));
        chk($sformatf("f%0d_mem_data_%0d", k, i), 32'(o_mem_data), (i * 37 + k * 5) & 32'hfff);
      end
    end
    we = 1'b0;
    if (!(v.rwl != 0 && v.n > 0)) begin
      vsync = 1'b1;
      tick();
      chk($sformatf("f%0d_done_early", k), 32'(o_frame_done), 0);
    end
    tick();
    chk($sformatf("f%0d_frame_done", k), 32'(o_frame_done), v.done);
    chk($sformatf("f%0d_frame_err", k), 32'(o_frame_err), v.err);
    chk($sformatf("f%0d_disp_bank", k), 32'(o_disp_bank), v.disp);
    chk($sformatf("f%0d_frozen", k), 32'(o_frozen), v.frozen);
    tick();
    chk($sformatf("f%0d_done_pulse_end", k), 32'(o_frame_done), 0);
    chk($sformatf("f%0d_err_pulse_end", k), 32'(o_frame_err), 0);
  endtask

  initial begin
    //          n  bad rwl fzs fzm wr msb dn er dp fr
    vecs[0]  = '{FP,     -1, 0, 0, -1, 1, 1, 1, 0, 1, 0};
    vecs[1]  = '{FP,     -1, 0, 0, -1, 1, 0, 1, 0, 0, 0};
    vecs[2]  = '{FP - 1, -1, 0, 0, -1, 1, 1, 0, 1, 0, 0};
    vecs[3]  = '{FP,     -1, 1, 0, -1, 1, 1, 1, 0, 1, 0};
    vecs[4]  = '{FP,      5, 0, 0, -1, 1, 0, 0, 1, 1, 0};
    vecs[5]  = '{0,      -1, 0, 0, -1, 1, 0, 0, 1, 1, 0};
    vecs[6]  = '{FP,     -1, 0, 0, -1, 1, 0, 1, 0, 0, 0};
    vecs[7]  = '{FP + 2, -1, 0, 0, -1, 1, 1, 0, 1, 0, 0};
    vecs[8]  = '{FP,     -1, 0, 0, 16, 1, 1, 1, 0, 1, 1};
    vecs[9]  = '{5,      -1, 0, 1, -1, 0, 0, 0, 0, 1, 1};
    vecs[10] = '{FP,     -1, 0, 0, -1, 1, 0, 1, 0, 0, 0};
    vecs[11] = '{FP,     -1, 0, 0, -1, 1, 1, 1, 0, 1, 0};

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_we", 32'(o_mem_we), 0);
    chk("rst_mem_addr", 32'(o_mem_addr), 0);
    chk("rst_disp_bank", 32'(o_disp_bank), 0);
    chk("rst_frozen", 32'(o_frozen), 0);
    rst = 1'b0;

    // Writes arriving mid-frame after reset are discarded; the following rise commits nothing.
    for (int i = 0; i < 10; i++) begin
      we = 1'b1; addr = AW'(i); data = DW'(i);
      tick();
      chk($sformatf("sync_mem_we_%0d", i), 32'(o_mem_we), 0);
    end
    we = 1'b0; vsync = 1'b1;
    repeat (3) begin
      tick();
      chk("sync_frame_done", 32'(o_frame_done), 0);
      chk("sync_frame_err", 32'(o_frame_err), 0);
    end
    chk("sync_disp_bank", 32'(o_disp_bank), 0);

    for (int k = 0; k < 11; k++) run_frame(k);

    // Asynchronous reset in the middle of a frame that is being written to bank 1.
    vsync = 1'b0; we = 1'b0;
    tick();
    for (int i = 0; i < 20; i++) begin
      we = 1'b1; addr = AW'(i); data = DW'(i + 100);
      tick();
      chk($sformatf("pre_rst_mem_we_%0d", i), 32'(o_mem_we), 1);
    end
    chk("pre_rst_mem_addr", 32'(o_mem_addr), (1 << AW) | 19);
    rst = 1'b1;
    #1;
    chk("mid_rst_mem_we", 32'(o_mem_we), 0);
    chk("mid_rst_mem_addr", 32'(o_mem_addr), 0);
    chk("mid_rst_mem_data", 32'(o_mem_data), 0);
    chk("mid_rst_disp_bank", 32'(o_disp_bank), 0);
    chk("mid_rst_frame_done", 32'(o_frame_done), 0);
    chk("mid_rst_frame_err", 32'(o_frame_err), 0);
    chk("mid_rst_frozen", 32'(o_frozen), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 20; i < 30; i++) begin
      we = 1'b1; addr = AW'(i); data = DW'(i);
      tick();
      chk($sformatf("post_rst_mem_we_%0d", i), 32'(o_mem_we), 0);
    end
    we = 1'b0; vsync = 1'b1;
    repeat (3) begin
      tick();
      chk("post_rst_frame_done", 32'(o_frame_done), 0);
    end
    chk("post_rst_disp_bank", 32'(o_disp_bank), 0);
    run_frame(11);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
